// File: rtl/loop_index_checker.sv
// loop_index_checker
// Consumer end of a loop-index stream. It accepts index beats over a
// valid/ready handshake and checks that they run 0,1,...,LAST and then wrap
// back to 0. It counts completed sequences and bad beats, and it resynchronises
// to the stream after an error.
//
// State table:
//   state | meaning
//   IDLE  | not accepting beats, expected held at 0
//   RUN   | accepting beats (unless stall), checking each against expected
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   start       in   IDLE -> RUN request (stop wins if both are high)
//   stop        in   return to IDLE and clear expected
//   stall       in   force in_ready low while in RUN
//   in_valid    in   index beat valid
//   in_index    in   index value [WIDTH]
//   in_ready    out  sink can accept (combinational)
//   expected    out  next expected index [WIDTH]
//   seq_count   out  completed sequences, wraps [CNT_W]
//   error_count out  bad beats, saturating [ERR_W]
//   seq_done    out  one-cycle pulse after a sequence completes
//   mismatch    out  one-cycle pulse after a bad beat
//   busy        out  high in RUN
module loop_index_checker #(
   parameter int WIDTH = 8,
   parameter int LAST  = 4,
   parameter int CNT_W = 16,
   parameter int ERR_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             stall,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_index,
   output logic             in_ready,
   output logic [WIDTH-1:0] expected,
   output logic [CNT_W-1:0] seq_count,
   output logic [ERR_W-1:0] error_count,
   output logic             seq_done,
   output logic             mismatch,
   output logic             busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

   state_t           state_q;
   state_t           state_d;
   logic             accept;
   logic [WIDTH-1:0] expected_d;
   logic             done_d;
   logic             mis_d;

   assign busy     = (state_q == RUN);
   assign in_ready = (state_q == RUN) && !stall;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start && !stop) state_d = RUN;
         RUN:  if (stop)           state_d = IDLE;
      endcase
   end

   always_comb begin
      expected_d = expected;
      done_d     = 1'b0;
      mis_d      = 1'b0;
      if (accept) begin
         if (in_index == expected) begin
            if (expected == LAST_V) begin
               expected_d = '0;
               done_d     = 1'b1;
            end else begin
               expected_d = expected + WIDTH'(1);
            end
         end else begin
            mis_d = 1'b1;
            // Resync: assume the bad beat is the producer's true position and
            // expect its successor; an out-of-range value restarts at 0.
            if (in_index > LAST_V || in_index == LAST_V) begin
               expected_d = '0;
            end else begin
               expected_d = in_index + WIDTH'(1);
            end
         end
      end
      // stop always leaves expected at 0, overriding the beat's update;
      // the beat's pulses and counters still take effect.
      if (stop) begin
         expected_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         expected    <= '0;
         seq_count   <= '0;
         error_count <= '0;
         seq_done    <= 1'b0;
         mismatch    <= 1'b0;
      end else begin
         state_q  <= state_d;
         expected <= expected_d;
         seq_done <= done_d;
         mismatch <= mis_d;
         if (done_d) begin
            seq_count <= seq_count + CNT_W'(1);
         end
         if (mis_d && (error_count != '1)) begin
            error_count <= error_count + ERR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_loop_index_checker.sv
// Bench for loop_index_checker: directed vector table, hand-written corner
// sequences (error saturation, mid-stream reset), then randomized traffic
// checked against an arithmetic reference model.
module tb_loop_index_checker;

   localparam int WIDTH = 8;
   localparam int LAST  = 4;
   localparam int CNT_W = 16;
   localparam int ERR_W = 4;
   localparam int ERR_MAX = (1 << ERR_W) - 1;
   localparam int CNT_MOD = 1 << CNT_W;

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic             stop;
   logic             stall;
   logic             in_valid;
   logic [WIDTH-1:0] in_index;
   logic             in_ready;
   logic [WIDTH-1:0] expected;
   logic [CNT_W-1:0] seq_count;
   logic [ERR_W-1:0] error_count;
   logic             seq_done;
   logic             mismatch;
   logic             busy;

   int n_checks = 0;
   int n_pass   = 0;

   loop_index_checker #(
      .WIDTH(WIDTH), .LAST(LAST), .CNT_W(CNT_W), .ERR_W(ERR_W)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .stall(stall),
      .in_valid(in_valid), .in_index(in_index), .in_ready(in_ready),
      .expected(expected), .seq_count(seq_count), .error_count(error_count),
      .seq_done(seq_done), .mismatch(mismatch), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic st, sp, sl, v;
      int   idx;
      int   rdy, ex, sq, er, dn, ms, bs;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic st, logic sp, logic sl, logic v, int idx,
                               int rdy, int ex, int sq, int er, int dn, int ms, int bs);
      vec_t r;
      r.st = st; r.sp = sp; r.sl = sl; r.v = v; r.idx = idx;
      r.rdy = rdy; r.ex = ex; r.sq = sq; r.er = er; r.dn = dn; r.ms = ms; r.bs = bs;
      return r;
   endfunction

   task automatic chk(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(logic st, logic sp, logic sl, logic v, int idx);
      start = st; stop = sp; stall = sl; in_valid = v; in_index = WIDTH'(idx);
   endtask

   task automatic chk_outs(string tag, int ex, int sq, int er, int dn, int ms, int bs);
      chk({tag, ".expected"},    int'(expected),    ex);
      chk({tag, ".seq_count"},   int'(seq_count),   sq);
      chk({tag, ".error_count"}, int'(error_count), er);
      chk({tag, ".seq_done"},    int'(seq_done),    dn);
      chk({tag, ".mismatch"},    int'(mismatch),    ms);
      chk({tag, ".busy"},        int'(busy),        bs);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_outs("reset", 0, 0, 0, 0, 0, 0);
      chk("reset.in_ready", int'(in_ready), 0);
   endtask

   // reference model state
   bit m_run;
   int m_exp, m_seq, m_err, m_done, m_mis;

   task automatic model_step(bit rst, bit st, bit sp, bit sl, bit v, int idx);
      bit acc;
      if (rst) begin
         m_run = 0; m_exp = 0; m_seq = 0; m_err = 0; m_done = 0; m_mis = 0;
         return;
      end
      acc = v && m_run && !sl;
      m_done = 0;
      m_mis  = 0;
      if (acc) begin
         if (idx == m_exp) begin
            if (m_exp == LAST) begin
               m_exp = 0; m_seq = (m_seq + 1) % CNT_MOD; m_done = 1;
            end else begin
               m_exp = m_exp + 1;
            end
         end else begin
            m_mis = 1;
            m_err = (m_err + 1 > ERR_MAX) ? ERR_MAX : m_err + 1;
            m_exp = (idx <= LAST) ? (idx + 1) % (LAST + 1) : 0;
         end
      end
      if (sp) m_exp = 0;
      if (m_run && sp) m_run = 0;
      else if (!m_run && st && !sp) m_run = 1;
   endtask

   initial begin
      int pulses;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);

      //          st sp sl v idx  rdy ex sq er dn ms bs
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1,  1, 2, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 2,  1, 3, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 3,  1, 4, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 4,  1, 0, 1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1,  1, 2, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 3,  1, 4, 1, 1, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 4,  1, 0, 2, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 7,  1, 0, 2, 2, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0,  1, 1, 2, 2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 1,  0, 1, 2, 2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 1,  0, 1, 2, 2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 1,  0, 1, 2, 2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1,  1, 2, 2, 2, 0, 0, 1));
      vecs.push_back(mk(0, 1, 0, 1, 2,  1, 0, 2, 2, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0,  0, 0, 2, 2, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 2, 2, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 2, 2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 4,  1, 0, 2, 3, 0, 1, 1));

      do_reset();
      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(vecs[i].st, vecs[i].sp, vecs[i].sl, vecs[i].v, vecs[i].idx);
         #1;
         chk({tag, ".in_ready"}, int'(in_ready), vecs[i].rdy);
         tick();
         chk_outs(tag, vecs[i].ex, vecs[i].sq, vecs[i].er, vecs[i].dn, vecs[i].ms, vecs[i].bs);
      end

      // 17 consecutive out-of-range beats: count climbs from 3 and sticks at max
      pulses = 0;
      for (int k = 1; k <= 17; k++) begin
         drive(0, 0, 0, 1, 9);
         tick();
         if (mismatch) pulses++;
         chk($sformatf("sat%0d.error_count", k), int'(error_count),
             (3 + k > ERR_MAX) ? ERR_MAX : 3 + k);
      end
      drive(0, 0, 0, 0, 0);
      tick();
      chk("sat.mismatch_pulses", pulses, 17);
      chk("sat.mismatch_idle", int'(mismatch), 0);
      chk("sat.expected", int'(expected), 0);

      // mid-stream reset
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1, k);
         tick();
      end
      chk("mid.expected_before", int'(expected), 3);
      drive(0, 0, 0, 1, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_outs("midrst", 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 0, 1, 0);
         #1;
         chk("midrst.in_ready", int'(in_ready), 0);
         tick();
         chk("midrst.expected", int'(expected), 0);
      end

      // randomized traffic against the reference model
      do_reset();
      model_step(1, 0, 0, 0, 0, 0);
      for (int c = 0; c < 3000; c++) begin
         bit r_rst, r_st, r_sp, r_sl, r_v;
         int r_idx, sel;
         r_rst = ($urandom_range(0, 199) == 0);
         r_st  = ($urandom_range(0, 3) == 0);
         r_sp  = ($urandom_range(0, 29) == 0);
         r_sl  = ($urandom_range(0, 4) == 0);
         r_v   = ($urandom_range(0, 3) != 0);
         sel   = $urandom_range(0, 9);
         if (sel < 7)      r_idx = m_exp;
         else if (sel < 9) r_idx = $urandom_range(0, LAST);
         else              r_idx = $urandom_range(LAST + 1, (1 << WIDTH) - 1);
         drive(r_st, r_sp, r_sl, r_v, r_idx);
         reset = r_rst;
         #1;
         chk("rnd.in_ready", int'(in_ready), int'(m_run && !r_sl));
         model_step(r_rst, r_st, r_sp, r_sl, r_v, r_idx);
         tick();
         reset = 1'b0;
         chk_outs("rnd", m_exp, m_seq, m_err, m_done, m_mis, int'(m_run));
         if (seq_done && mismatch) chk("rnd.pulse_exclusive", 1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/loop_index_checker.md
Name: loop_index_checker

Overview:
- Consumer end of the loop-index stream: receives a stream of loop index values over a valid/ready handshake.
- Checks that each index follows 0,1,...,LAST and then wraps to 0.
- Counts completed sequences and mismatches, and resynchronises after an error.
- Sits beside loop-driven producer blocks as a self-checking sink for benches and debug.

Parameters:
WIDTH, 8, width of the index bus and of the expected register
LAST, 4, final index of one sequence (must be < 2**WIDTH)
CNT_W, 16, width of seq_count
ERR_W, 4, width of error_count (saturating)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  IDLE->RUN request
stop  input  1  return to IDLE, clear expected
stall  input  1  force in_ready low while in RUN
in_valid  input  1  index beat valid
in_index  input  WIDTH  index value
in_ready  output  1  sink can accept
expected  output  WIDTH  next expected index
seq_count  output  CNT_W  completed sequences (wraps modulo 2**CNT_W)
error_count  output  ERR_W  mismatches, saturates at all-ones
seq_done  output  1  one-cycle pulse, sequence completed
mismatch  output  1  one-cycle pulse, bad beat
busy  output  1  high in RUN

Behaviour:
- Reset values (sampled on a clock edge with reset=1): state IDLE, in_ready=0, expected=0, seq_count=0, error_count=0, seq_done=0, mismatch=0, busy=0.
- Reset overrides every other input.
- States: IDLE, RUN.
  - IDLE: start=1 and stop=0 -> RUN next cycle. If start and stop are both 1, stop wins and the block stays in IDLE.
  - RUN: stop=1 -> IDLE next cycle and expected<=0. seq_count and error_count are held.
- in_ready is combinational: (state==RUN) && !stall.
- Accept condition: in_valid && in_ready. Beats with in_valid while not ready are ignored; the producer holds the beat.
- On an accepted beat (all updates registered, visible the next cycle):
  - in_index==expected:
    - If expected==LAST: expected<=0, seq_count+1, seq_done=1.
    - Otherwise: expected+1.
  - in_index!=expected and in_index<=LAST: mismatch=1, error_count+1 (saturating). Resync:
    - If in_index==LAST: expected<=0. No seq_done and no seq_count increment.
    - Otherwise: expected<=in_index+1.
  - in_index>LAST: mismatch=1, error_count+1 (saturating), expected<=0.
- seq_done and mismatch are 1 only in the cycle after the accepting edge; otherwise 0. They are never both 1.
- stop in the same cycle as an accepted beat: the beat is fully checked and counted, then state goes to IDLE and expected<=0. Clearing expected takes priority over the beat's expected update.
- error_count saturates at 2**ERR_W-1 with no wrap. mismatch still pulses on every bad beat.
- Latency: 1 cycle from accepting edge to updated outputs. Throughput: one beat per cycle.

Test Plan:
- Reset, start, then 0,1,2,3,4 back-to-back (LAST=4) -> in_ready=1 throughout, seq_done pulses once after beat 4, seq_count=1, error_count=0, expected=0.
- RUN, send 0,1,3,4 -> mismatch pulses after beat 3, error_count=1, expected=4; beat 4 accepted as valid -> seq_done, seq_count=1, expected=0.
- RUN, send 7 -> mismatch, error_count=1, expected=0; then 0 is accepted without error -> expected=1.
- RUN, stall=1 with in_valid=1/in_index=0 held for 3 cycles -> in_ready=0, expected stays 0, no pulses; release stall -> exactly one beat accepted, expected=1.
- ERR_W=4, 17 consecutive bad beats (value 9) -> error_count=15, stays 15, mismatch pulses 17 times.
- Send 0,1,2, then reset mid-stream -> all outputs back to reset values, state IDLE; in_valid beats ignored (in_ready=0) until start.
- Start and stop together in IDLE -> stays IDLE, busy=0. stop together with an accepted beat 2 (expected=2) -> expected=0, state IDLE, no mismatch.
